// File: rtl/bk_operand_loader_if.sv
// Stream, result and adder-side signals of the Brent-Kung operand loader.
// The loader is the slave; the stream source / result sink / adder is the master.
interface bk_operand_loader_if #(
  parameter int unsigned OP_WIDTH   = 12,
  parameter int unsigned BEAT_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [BEAT_WIDTH-1:0]   in_data;
  logic                    in_last;
  logic [2*OP_WIDTH-1:0]   adder_in;
  logic [OP_WIDTH:0]       adder_sum;
  logic                    res_valid;
  logic                    res_ready;
  logic [OP_WIDTH:0]       res_sum;
  logic                    err_frame;
  logic [CNT_WIDTH-1:0]    pair_count;

  modport slave (
    input  in_valid, in_data, in_last, adder_sum, res_ready,
    output in_ready, adder_in, res_valid, res_sum, err_frame, pair_count
  );

  modport master (
    output in_valid, in_data, in_last, adder_sum, res_ready,
    input  in_ready, adder_in, res_valid, res_sum, err_frame, pair_count
  );
endinterface

// File: rtl/bk_operand_loader.sv
// Nibble-serial operand assembler feeding a 12-bit Brent-Kung adder and
// capturing its sum behind a valid/ready result port.
module bk_operand_loader #(
  parameter int unsigned OP_WIDTH   = 12,
  parameter int unsigned BEAT_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  bk_operand_loader_if.slave bus
);

  localparam int unsigned BEATS = 2 * OP_WIDTH / BEAT_WIDTH;
  localparam int unsigned BCW   = $clog2(BEATS);
  localparam int unsigned SHW   = 2 * OP_WIDTH - BEAT_WIDTH;
  localparam int unsigned VW    = 2 * OP_WIDTH;

  typedef enum logic [1:0] {LOAD, EVAL, HOLD} state_t;

  state_t               state, state_nxt;
  logic [BCW-1:0]       beat_cnt;
  logic [SHW-1:0]       shadow;
  logic [VW-1:0]        adder_in_q;
  logic [VW-1:0]        frame_c;
  logic [VW-1:0]        interleaved_c;
  logic [OP_WIDTH:0]    res_sum_q;
  logic                 in_ready_q;
  logic                 res_valid_q;
  logic                 err_frame_q;
  logic [CNT_WIDTH-1:0] pair_count_q;
  logic                 accept_c;
  logic                 at_end_c;
  logic                 load_c;
  logic                 frame_err_c;
  logic                 capture_c;

  // Next state and datapath strobes
  always_comb begin
    state_nxt   = state;
    accept_c    = 1'b0;
    load_c      = 1'b0;
    frame_err_c = 1'b0;
    capture_c   = 1'b0;
    at_end_c    = (beat_cnt == BCW'(BEATS - 1));
    unique case (state)
      LOAD: begin
        accept_c = bus.in_valid & in_ready_q;
        if (accept_c) begin
          if (bus.in_last && at_end_c) begin
            load_c    = 1'b1;
            state_nxt = EVAL;
          end else if (bus.in_last || at_end_c) begin
            frame_err_c = 1'b1;
          end
        end
      end
      EVAL: begin
        capture_c = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Final beat on top of the shadow, then A/B bit-interleaved for the adder
  always_comb begin
    frame_c       = {bus.in_data, shadow};
    interleaved_c = '0;
    for (int i = 0; i < int'(OP_WIDTH); i++) begin
      interleaved_c[2*i]   = frame_c[i];
      interleaved_c[2*i+1] = frame_c[int'(OP_WIDTH) + i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Shadow is a right-shifting register: after BEATS-1 beats the first beat sits in the LSBs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt     <= '0;
      shadow       <= '0;
      adder_in_q   <= '0;
      res_sum_q    <= '0;
      in_ready_q   <= 1'b1;
      res_valid_q  <= 1'b0;
      err_frame_q  <= 1'b0;
      pair_count_q <= '0;
    end else begin
      in_ready_q  <= (state_nxt == LOAD);
      res_valid_q <= (state_nxt == HOLD);
      err_frame_q <= frame_err_c;
      if (accept_c) begin
        if (load_c || frame_err_c) beat_cnt <= '0;
        else                       beat_cnt <= beat_cnt + BCW'(1);
        if (frame_err_c) shadow <= '0;
        else             shadow <= {bus.in_data, shadow[SHW-1:BEAT_WIDTH]};
      end
      if (load_c) adder_in_q <= interleaved_c;
      if (capture_c) begin
        res_sum_q    <= bus.adder_sum;
        pair_count_q <= pair_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.adder_in   = adder_in_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_sum    = res_sum_q;
  assign bus.err_frame  = err_frame_q;
  assign bus.pair_count = pair_count_q;

endmodule
